// File: rtl/tpu_pkg.sv
// Shared types and constants for the systolic array control blocks.
package tpu_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SEND,
        SHIFT,
        DONE
    } drain_state_t;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_drain.sv
// Drains the PE output chains column by column onto a valid/ready byte stream.
// Optional DRAIN_LAST_EN adds out_last framing on the final byte of the drain.
//
// state   | meaning
// IDLE    | waiting for start
// CAPTURE | latch chain-tail accumulators of every row
// SEND    | stream captured bytes, row 0 first
// SHIFT   | one-cycle chain shift to bring next column to the tail
// DONE    | one-cycle completion pulse
module systolic_drain
    import tpu_pkg::*;
#(
    parameter int ROWS = 2,
    parameter int COLS = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ROWS*DATA_W-1:0]   tail_c,
    output logic                     chain_en,
    output logic [DATA_W-1:0]        chain_head,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef DRAIN_LAST_EN
    ,
    output logic                     out_last
`endif
);

    localparam int RW = idx_w(ROWS);
    localparam int CW = idx_w(COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    drain_state_t              state;
    drain_state_t              state_nxt;
    logic [RW-1:0]             row_idx;
    logic [CW-1:0]             col_idx;
    logic [ROWS*DATA_W-1:0]    hold;
    logic                      handshake;

    assign handshake = (state == SEND) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CAPTURE;
            CAPTURE: state_nxt = SEND;
            SEND: begin
                if (handshake && (row_idx == ROW_LAST)) begin
                    state_nxt = (col_idx == COL_LAST) ? DONE : SHIFT;
                end
            end
            SHIFT:   state_nxt = CAPTURE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_idx <= '0;
            col_idx <= '0;
            hold    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) col_idx <= '0;
                end
                CAPTURE: begin
                    hold    <= tail_c;
                    row_idx <= '0;
                end
                SEND: begin
                    if (handshake && (row_idx != ROW_LAST)) row_idx <= row_idx + 1'b1;
                end
                SHIFT: begin
                    col_idx <= col_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Every output is a decode of registered state, so no input reaches an output.
    assign out_valid  = (state == SEND);
    assign out_data   = out_valid ? hold[row_idx*DATA_W +: DATA_W] : '0;
    assign chain_en   = (state == SHIFT);
    assign chain_head = '0;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

`ifdef DRAIN_LAST_EN
    assign out_last = (state == SEND) && (row_idx == ROW_LAST) && (col_idx == COL_LAST);
`endif

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: 2x2 with a PE chain model and a 4x1 instance.
module tb_systolic_drain;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rdy = 1'b1;
    int          sel = 0;

    logic        start_a, ce_a, busy_a, done_a, valid_a;
    logic [15:0] tail_a;
    logic [7:0]  head_a, data_a;
    logic        start_b, ce_b, busy_b, done_b, valid_b;
    logic [31:0] tail_b;
    logic [7:0]  head_b, data_b;
    logic        last_a, last_b;

    logic        ce, busy, done, v, last;
    logic [7:0]  d;

    logic [7:0]  pe [2][2];
    logic        pe_load = 1'b0;
    logic [7:0]  exp_b [4];

    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign tail_b  = 32'hDDCCBBAA;
    assign tail_a  = {pe[1][1], pe[0][1]};

    systolic_drain #(.ROWS(2), .COLS(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .tail_c(tail_a),
        .chain_en(ce_a), .chain_head(head_a), .busy(busy_a), .done(done_a),
        .out_data(data_a), .out_valid(valid_a), .out_ready(rdy)
`ifdef DRAIN_LAST_EN
        , .out_last(last_a)
`endif
    );

    systolic_drain #(.ROWS(4), .COLS(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .tail_c(tail_b),
        .chain_en(ce_b), .chain_head(head_b), .busy(busy_b), .done(done_b),
        .out_data(data_b), .out_valid(valid_b), .out_ready(rdy)
`ifdef DRAIN_LAST_EN
        , .out_last(last_b)
`endif
    );

`ifndef DRAIN_LAST_EN
    assign last_a = 1'b0;
    assign last_b = 1'b0;
`endif

    always_comb begin
        ce = ce_a; busy = busy_a; done = done_a; v = valid_a; d = data_a; last = last_a;
        if (sel == 1) begin
            ce = ce_b; busy = busy_b; done = done_b; v = valid_b; d = data_b; last = last_b;
        end
    end

    // Two-PE-per-row chain: column 1 is the tail, column 0 takes chain_head.
    always @(posedge clk) begin
        if (pe_load) begin
            pe[0][0] <= 8'h33; pe[0][1] <= 8'h11;
            pe[1][0] <= 8'h44; pe[1][1] <= 8'h22;
        end else if (ce_a) begin
            for (int r = 0; r < 2; r++) begin
                pe[r][1] <= pe[r][0];
                pe[r][0] <= head_a;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic reload_pe();
        pe_load = 1'b1;
        @(posedge clk); #1;
        pe_load = 1'b0;
    endtask

    task automatic set_exp_2x2();
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    endtask

    // Runs one drain from IDLE; called #1 after a rising edge.
    task automatic drain(input int s, input int stall_byte, input int stall_n, input bit repulse,
                         input int nexp, input int done_exp, input int shifts_exp, input int shift_cyc_exp);
        int k, nb, st, nsh, shc;
        bit got;
        sel = s; start = 1'b1; rdy = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 1; nb = 0; st = 0; nsh = 0; shc = -1; got = 1'b0;
        while (!got && k < 80) begin
            rdy = !(nb == stall_byte && st < stall_n);
            if (repulse) start = (k == 3);
            #1;
            if (v && !rdy) begin
                st++;
                check_eq("stall_data", d, exp_b[nb]);
                check_eq("stall_chain_en", ce, 0);
`ifdef DRAIN_LAST_EN
                check_eq("stall_last", last, nb == nexp - 1);
`endif
            end
            if (ce) begin
                nsh++;
                shc = k;
            end
            if (v && rdy) begin
                if (nb < nexp) begin
                    check_eq("byte", d, exp_b[nb]);
`ifdef DRAIN_LAST_EN
                    check_eq("last", last, nb == nexp - 1);
`endif
                end else begin
                    check_eq("extra_byte", nb, nexp - 1);
                end
                nb++;
            end
            if (done) begin
                got = 1'b1;
                check_eq("done_cycle", k, done_exp);
            end else begin
                @(posedge clk); #1;
                k++;
            end
        end
        start = 1'b0;
        rdy = 1'b1;
        check_eq("done_seen", got, 1);
        check_eq("byte_count", nb, nexp);
        check_eq("shift_count", nsh, shifts_exp);
        if (shifts_exp > 0) check_eq("shift_cycle", shc, shift_cyc_exp);
        @(posedge clk); #1;
        check_eq("busy_after_done", busy, 0);
    endtask

    initial begin
        pe_load = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", valid_a, 0);
        check_eq("rst_chain_en", ce_a, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_done", done_a, 0);
        check_eq("rst_data", data_a, 0);
        check_eq("rst_valid_b", valid_b, 0);
`ifdef DRAIN_LAST_EN
        check_eq("rst_last", last_a, 0);
`endif
        rst_n = 1'b1;
        pe_load = 1'b0;
        check_eq("chain_head", head_a, 0);

        // Plain 2x2 drain
        set_exp_2x2();
        reload_pe();
        drain(0, -1, 0, 1'b0, 4, 8, 1, 4);
        check_eq("zero_fill_r0", pe[0][0], 0);
        check_eq("zero_fill_r1", pe[1][0], 0);

        // Stall 3 cycles on second byte
        reload_pe();
        drain(0, 1, 3, 1'b0, 4, 11, 1, 7);

        // Start re-pulsed during SEND must be ignored
        reload_pe();
        drain(0, -1, 0, 1'b1, 4, 8, 1, 4);
        repeat (3) @(posedge clk);
        #1;
        check_eq("no_requeue_busy", busy_a, 0);

        // Reset asserted while in SHIFT
        reload_pe();
        sel = 0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("shift_reached", ce_a, 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_chain_en", ce_a, 0);
        check_eq("rst_mid_valid", valid_a, 0);
        check_eq("rst_mid_busy", busy_a, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        reload_pe();
        drain(0, -1, 0, 1'b0, 4, 8, 1, 4);

        // Stall on the final byte (exercises out_last hold when enabled)
        reload_pe();
        drain(0, 3, 2, 1'b0, 4, 10, 1, 4);

        // 4x1 instance: no shift, four bytes
        exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC; exp_b[3] = 8'hDD;
        drain(1, -1, 0, 1'b0, 4, 6, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
